// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, reference colours and the vga_reader state encoding.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int V_ACTIVE_DEF = 768;

  localparam int COL_W = 11;
  localparam int ROW_W = 10;
  localparam int CNT_W = 20;

  localparam logic [23:0] ROVER_COLOR          = 24'hFF0000;
  localparam logic [23:0] TARGET_COLOR         = 24'h00FF00;
  localparam logic [23:0] ROVER_ORIENTED_COLOR = 24'h0000FF;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ACTIVE = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/bbox_accumulator.sv
// Running bounding box and saturating hit count for one frame of matched pixels.
// The *_d outputs include the current cycle's hit so a frame can be closed on the same edge.
module bbox_accumulator
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             hit,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] x_min_d,
  output logic [COL_W-1:0] x_max_d,
  output logic [ROW_W-1:0] y_min_d,
  output logic [ROW_W-1:0] y_max_d,
  output logic [CNT_W-1:0] count_d
);

  logic [COL_W-1:0] x_min_q, x_max_q;
  logic [ROW_W-1:0] y_min_q, y_max_q;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    x_min_d = x_min_q;
    x_max_d = x_max_q;
    y_min_d = y_min_q;
    y_max_d = y_max_q;
    count_d = count_q;
    if (hit) begin
      if (col < x_min_q) x_min_d = col;
      if (col > x_max_q) x_max_d = col;
      if (row < y_min_q) y_min_d = row;
      if (row > y_max_q) y_max_d = row;
      if (count_q != '1) count_d = count_q + 1'b1;
    end
  end

  // Minima start at all-ones so the first hit always replaces them.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      x_min_q <= '1;
      x_max_q <= '0;
      y_min_q <= '1;
      y_max_q <= '0;
      count_q <= '0;
    end else begin
      x_min_q <= x_min_d;
      x_max_q <= x_max_d;
      y_min_q <= y_min_d;
      y_max_q <= y_max_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_reader.sv
// Locates pixels of a chosen colour in each frame and reports their bounding box.
// Define VGA_READER_CENTROID_EN to add the signed center_x/center_y outputs.
module vga_reader
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE   = H_ACTIVE_DEF,
  parameter int          V_ACTIVE   = V_ACTIVE_DEF,
  parameter logic [23:0] MATCH_MASK = 24'hFF_FF_FF
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        phsync,
  input  logic        pvsync,
  input  logic        pblank,
  input  logic [23:0] pixel,
  input  logic [23:0] match_color,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max,
  output logic [19:0] match_count,
  output logic        found,
  output logic        frame_done,
  output logic        sync_error
`ifdef VGA_READER_CENTROID_EN
  ,
  output logic signed [11:0] center_x,
  output logic signed [11:0] center_y
`endif
);

  localparam logic [COL_W-1:0] COL_END = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] COL_LIM = COL_W'(H_ACTIVE + 1);
  localparam logic [ROW_W-1:0] ROW_END = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_LIM = ROW_W'(V_ACTIVE + 1);

  state_t           state_q, state_d;
  logic             phsync_q, pvsync_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             err_q, err_d;
  logic [23:0]      color_q, color_d;
  logic [10:0]      x_min_q, x_min_d, x_max_q, x_max_d;
  logic [9:0]       y_min_q, y_min_d, y_max_q, y_max_d;
  logic [19:0]      match_count_q, match_count_d;
  logic             found_q, found_d, frame_done_q, frame_done_d, sync_error_q, sync_error_d;

  logic             hsync_fall, vsync_fall, tracking, hit, line_done, frame_end, frame_err;
  logic [COL_W-1:0] acc_x_min, acc_x_max;
  logic [ROW_W-1:0] acc_y_min, acc_y_max;
  logic [CNT_W-1:0] acc_count;

`ifdef VGA_READER_CENTROID_EN
  logic signed [11:0] center_x_q, center_x_d, center_y_q, center_y_d;
  logic [11:0]        sum_x;
  logic [10:0]        sum_y;
`endif

  bbox_accumulator u_acc (
    .clk     (vclock),
    .srst    (reset),
    .clear   (vsync_fall),
    .hit     (hit),
    .col     (col_q),
    .row     (row_q),
    .x_min_d (acc_x_min),
    .x_max_d (acc_x_max),
    .y_min_d (acc_y_min),
    .y_max_d (acc_y_max),
    .count_d (acc_count)
  );

  always_comb begin
    hsync_fall = phsync_q & ~phsync;
    vsync_fall = pvsync_q & ~pvsync;
    tracking   = (state_q != SEEK);
    hit        = tracking & ~pblank & ((pixel & MATCH_MASK) == (color_q & MATCH_MASK));
    line_done  = hsync_fall & (col_q != '0);
    frame_end  = (state_q == ACTIVE) & vsync_fall;

    col_d = col_q;
    row_d = row_q;
    err_d = err_q;
    // A completed line closes with the count it reached before this hsync edge.
    if (line_done) begin
      if (col_q != COL_END) err_d = 1'b1;
      if (row_q != ROW_LIM) row_d = row_q + 1'b1;
      if (row_d == ROW_LIM) err_d = 1'b1;
    end
    if (hsync_fall) col_d = '0;
    if (tracking && !pblank) begin
      if (col_d != COL_LIM) col_d = col_d + 1'b1;
      if (col_d == COL_LIM) err_d = 1'b1;
    end
    frame_err = err_d | (row_d != ROW_END);
    if (vsync_fall) begin
      col_d = '0;
      row_d = '0;
      err_d = 1'b0;
    end

    state_d       = state_q;
    color_d       = color_q;
    x_min_d       = x_min_q;
    x_max_d       = x_max_q;
    y_min_d       = y_min_q;
    y_max_d       = y_max_q;
    match_count_d = match_count_q;
    found_d       = found_q;
    sync_error_d  = sync_error_q;
    frame_done_d  = 1'b0;
    case (state_q)
      SEEK:    if (vsync_fall) state_d = ACTIVE;
      ACTIVE:  if (vsync_fall) state_d = REPORT;
      REPORT: begin
        state_d = ACTIVE;
        color_d = match_color;
      end
      default: state_d = SEEK;
    endcase

    // Results are captured on the edge entering REPORT so they are valid with frame_done.
    if (frame_end) begin
      found_d       = (acc_count != '0);
      x_min_d       = found_d ? acc_x_min : '0;
      x_max_d       = found_d ? acc_x_max : '0;
      y_min_d       = found_d ? acc_y_min : '0;
      y_max_d       = found_d ? acc_y_max : '0;
      match_count_d = acc_count;
      sync_error_d  = frame_err;
      frame_done_d  = 1'b1;
    end

`ifdef VGA_READER_CENTROID_EN
    sum_x      = 12'(acc_x_min) + 12'(acc_x_max);
    sum_y      = 11'(acc_y_min) + 11'(acc_y_max);
    center_x_d = center_x_q;
    center_y_d = center_y_q;
    if (frame_end) begin
      center_x_d = found_d ? $signed((sum_x >> 1) - 12'(H_ACTIVE / 2)) : 12'sd0;
      center_y_d = found_d ? $signed(12'(V_ACTIVE) - 12'(sum_y >> 1)) : 12'sd0;
    end
`endif
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      state_q       <= SEEK;
      phsync_q      <= 1'b0;
      pvsync_q      <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      err_q         <= 1'b0;
      color_q       <= '0;
      x_min_q       <= '0;
      x_max_q       <= '0;
      y_min_q       <= '0;
      y_max_q       <= '0;
      match_count_q <= '0;
      found_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_error_q  <= 1'b0;
`ifdef VGA_READER_CENTROID_EN
      center_x_q    <= '0;
      center_y_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      phsync_q      <= phsync;
      pvsync_q      <= pvsync;
      col_q         <= col_d;
      row_q         <= row_d;
      err_q         <= err_d;
      color_q       <= color_d;
      x_min_q       <= x_min_d;
      x_max_q       <= x_max_d;
      y_min_q       <= y_min_d;
      y_max_q       <= y_max_d;
      match_count_q <= match_count_d;
      found_q       <= found_d;
      frame_done_q  <= frame_done_d;
      sync_error_q  <= sync_error_d;
`ifdef VGA_READER_CENTROID_EN
      center_x_q    <= center_x_d;
      center_y_q    <= center_y_d;
`endif
    end
  end

  assign x_min       = x_min_q;
  assign x_max       = x_max_q;
  assign y_min       = y_min_q;
  assign y_max       = y_max_q;
  assign match_count = match_count_q;
  assign found       = found_q;
  assign frame_done  = frame_done_q;
  assign sync_error  = sync_error_q;
`ifdef VGA_READER_CENTROID_EN
  assign center_x    = center_x_q;
  assign center_y    = center_y_q;
`endif

endmodule
